fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front-end sitting directly upstream of the instruction-side memory interface. Generates sequential PCs and issues one read request per cycle to the memory interface (1-cycle request->valid latency). Buffers returned instructions with their PCs in a small FIFO for decode, and handles redirects (branch/jump/trap) by flushing queued and in-flight fetches.

Parameters:
XLEN, 32, PC/address and instruction width
RESET_PC, 32'h0000_0000, first PC fetched after reset
FQ_DEPTH, 4, fetch queue entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
mem_request  output  1  read request to memory interface
mem_we  output  1  write enable to memory; constant 0
mem_addr  output  XLEN  byte address of request; bits [1:0] always 0
mem_valid  input  1  response valid, one cycle after an accepted mem_request
mem_rdata  input  XLEN  instruction word; sampled only when mem_valid=1
redirect_valid  input  1  redirect PC this cycle
redirect_pc  input  XLEN  new fetch target
out_valid  output  1  fetch queue head valid
out_ready  input  1  decode accepts head
out_instr  output  XLEN  head instruction
out_pc  output  XLEN  head PC

Behaviour:
- Clocking: clk only. Reset: rst_n, synchronous, active-low. During reset: mem_request=0, out_valid=0, queue empty, inflight=0, pc=RESET_PC, state=IDLE.
- States: IDLE (one cycle after reset release, no request) -> FETCH. FETCH <-> STALL on credits. Any state + redirect_valid -> FETCH with new PC.
- Credit rule: issue in a cycle iff state=FETCH, !redirect_valid, and (fq_count + inflight + mem_valid_accepted_this_cycle_pop_adjusted) < FQ_DEPTH. Simple legal form: issue iff fq_count + inflight < FQ_DEPTH, counting this cycle's pop as freeing one slot. inflight is 0 or 1: the response arrives the cycle after issue.
- Issue: mem_request=1 and mem_addr=pc combinationally from registered pc. pc <= pc+4 (wraps modulo 2^XLEN). No credit -> STALL, mem_request=0, pc holds.
- Response: mem_valid=1 and not killed -> push {pc_of_request, mem_rdata}. The request PC is held in a 1-entry inflight register.
- Pop: out_valid && out_ready -> head removed. Push and pop in the same cycle are both allowed; count unchanged. Push into a full queue cannot occur by credit rule; assert in simulation.
- Redirect (redirect_valid=1): queue flushed (count=0, out_valid=0 next cycle). Any inflight request is marked killed, so its response next cycle is dropped. pc <= {redirect_pc[XLEN-1:2],2'b00}. No request issued in the redirect cycle; first redirected request is issued the following cycle.
- A pop in the redirect cycle is still a valid handshake (decode owns the squash).
- Back-to-back redirects: the last one wins; each kills its predecessor's inflight.
- Latency: redirect at cycle N -> request at N+1 -> mem_valid at N+2 -> out_valid at N+3 (registered queue output).
- Reset mid-operation: all state cleared; a late mem_valid in the first cycle after reset is ignored (inflight=0).

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds output ports perf_issued[31:0] and perf_dropped[31:0]. perf_issued counts cycles with mem_request=1. perf_dropped counts killed responses plus flushed queue entries. Both cleared on reset, saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; other behaviour is identical.

Test Plan:
- Reset release, out_ready=1 constant, memory returns addr-as-data -> mem_addr 0x0,0x4,0x8,... one per cycle from cycle 1. out_pc/out_instr 0x0 appears at cycle 3, then one per cycle.
- out_ready=0 -> exactly 4 requests (0x0..0xC). Then mem_request=0, out_valid=1, pc holds 0x10. Raise out_ready -> fetch resumes at 0x10 with no gaps or duplicates.
- Redirect to 0x100 in the cycle after the request for 0x8 -> 0x8 response dropped, queue empty. Next request is 0x100, and out_pc=0x100 appears 3 cycles after the redirect.
- Redirect to 0x203 -> mem_addr=0x200.
- Redirect on cycles N and N+1 (0x40, then 0x80) -> only 0x80 stream reaches output, with no 0x40 entries.
- With FETCH_PERF_CNT_EN: run the redirect scenario -> perf_dropped equals the killed response count plus the flushed entry count. perf_issued equals the number of mem_request cycles.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch front-end with a credit-limited fetch queue and redirect flush.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf_issued / perf_dropped counters.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              FQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_request,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_dropped
`endif
);
    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = CW + 1;
    localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);

    typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ifl_pc_q, ifl_pc_d;
    logic            ifl_q, ifl_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] fq_pc_q    [FQ_DEPTH];
    logic [XLEN-1:0] fq_instr_q [FQ_DEPTH];
    logic            pop, push, credit;
    logic [OW-1:0]   occ;

    // Next-state logic: credit check counts the in-flight slot and frees the slot popped this cycle
    always_comb begin
        out_valid   = rst_n && (count_q != '0);
        out_instr   = fq_instr_q[rd_ptr_q];
        out_pc      = fq_pc_q[rd_ptr_q];
        pop         = out_valid && out_ready;
        push        = mem_valid && ifl_q && !redirect_valid;
        occ         = {1'b0, count_q} + OW'(ifl_q);
        credit      = occ < OW'(FQ_DEPTH) + OW'(pop);
        mem_request = rst_n && (state_q != IDLE) && !redirect_valid && credit;
        mem_we      = 1'b0;
        mem_addr    = pc_q;
        pc_d        = redirect_valid ? (redirect_pc & ALIGN) : mem_request ? pc_q + XLEN'(4) : pc_q;
        state_d     = (state_q == IDLE || redirect_valid || credit) ? FETCH : STALL;
        ifl_d       = mem_request;
        ifl_pc_d    = mem_request ? pc_q : ifl_pc_q;
        count_d     = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
        rd_ptr_d    = redirect_valid ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d    = redirect_valid ? '0 : wr_ptr_q + AW'(push);
    end

    // Control state: FSM, PC, in-flight tracker and queue pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC & ALIGN;
            ifl_q    <= 1'b0;
            ifl_pc_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ifl_q    <= ifl_d;
            ifl_pc_q <= ifl_pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Queue storage: pair each returned word with the PC of the request that fetched it
    always_ff @(posedge clk) begin
        if (push) begin
            fq_pc_q[wr_ptr_q]    <= ifl_pc_q;
            fq_instr_q[wr_ptr_q] <= mem_rdata;
        end
        if (rst_n && push && !pop) assert (count_q != CW'(FQ_DEPTH));
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_dropped_q, perf_dropped_d;
    logic [32:0] issued_sum, dropped_sum;

    // Counter increments: dropped = killed response plus entries still queued after this cycle's pop
    always_comb begin
        issued_sum     = {1'b0, perf_issued_q} + 33'(mem_request);
        dropped_sum    = {1'b0, perf_dropped_q} + 33'(mem_valid && ifl_q && redirect_valid)
                       + (redirect_valid ? 33'(count_q - CW'(pop)) : 33'd0);
        perf_issued_d  = issued_sum[32] ? '1 : issued_sum[31:0];
        perf_dropped_d = dropped_sum[32] ? '1 : dropped_sum[31:0];
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued_q  <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_dropped_q <= perf_dropped_d;
        end
    end

    assign perf_issued  = perf_issued_q;
    assign perf_dropped = perf_dropped_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table vectors, directed corner sequences and random traffic checked against a queue-based model.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hC0DE_5A00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_request, mem_we;
    logic [31:0] mem_addr;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_issued, perf_dropped;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ereq;
        logic [31:0] eaddr;
        logic        eov;
        logic [31:0] epc;
    } vec_t;

    ent_t        q[$];
    logic        m_started = 1'b0;
    logic        m_inflight = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_ipc = '0;
    longint      m_issued = 0;
    longint      m_dropped = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_request    (mem_request),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_valid      (mem_valid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_issued    (perf_issued),
        .perf_dropped   (perf_dropped)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, advance model, answer memory one cycle later
    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                        output logic o_req, output logic [31:0] o_addr,
                        output logic o_ov, output logic [31:0] o_pc);
        logic        exp_ov, exp_req, pop, last_req;
        logic [31:0] last_addr;
        int          occ;
        rst_n = !rst;
        redirect_valid = rv;
        redirect_pc = rpc;
        out_ready = rdy;
        #1;
        exp_ov  = !rst && q.size() > 0;
        pop     = exp_ov && rdy;
        occ     = q.size() + int'(m_inflight) - int'(pop);
        exp_req = !rst && m_started && !rv && occ < 4;
        chk("mem_request", mem_request, exp_req);
        chk("mem_we", mem_we, 0);
        if (exp_req) chk("mem_addr", mem_addr, m_pc);
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) begin
            chk("out_pc", out_pc, q[0].pc);
            chk("out_instr", out_instr, q[0].instr);
        end
        o_req = mem_request;
        o_addr = mem_addr;
        o_ov = out_valid;
        o_pc = out_pc;
        last_req = mem_request;
        last_addr = mem_addr;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_started = 0;
            m_inflight = 0;
            m_pc = 32'h0;
            m_issued = 0;
            m_dropped = 0;
        end else begin
            if (pop) void'(q.pop_front());
            if (rv) begin
                m_dropped += q.size() + ((mem_valid && m_inflight) ? 1 : 0);
                q.delete();
            end else if (mem_valid && m_inflight) begin
                q.push_back('{m_ipc, mem_rdata});
            end
            if (exp_req) m_issued++;
            m_ipc = m_pc;
            m_inflight = exp_req;
            m_pc = rv ? {rpc[31:2], 2'b00} : exp_req ? m_pc + 32'd4 : m_pc;
            m_started = 1;
        end
        #1;
        mem_valid = last_req;
        mem_rdata = last_addr ^ KEY;
    endtask

    task automatic do_reset();
        logic r, v;
        logic [31:0] a, p;
        step(1, 0, 0, 1, r, a, v, p);
        step(1, 0, 0, 1, r, a, v, p);
    endtask

    initial begin
        vec_t        tbl[9];
        logic        r, v;
        logic [31:0] a, p, first_pc;
        int          nreq, n40;
        logic        found;

        tbl[0] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
        tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h4,   1'b0, 32'h0};
        tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h8,   1'b1, 32'h0};
        tbl[4] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'hC,   1'b1, 32'h4};
        tbl[5] = '{1'b1, 32'h203, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8};
        tbl[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h0};
        tbl[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h200};

        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 9; i++) begin
            step(0, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, r, a, v, p);
            chk("tbl_req", r, tbl[i].ereq);
            if (tbl[i].ereq) chk("tbl_addr", a, tbl[i].eaddr);
            chk("tbl_ov", v, tbl[i].eov);
            if (tbl[i].eov) chk("tbl_pc", p, tbl[i].epc);
        end

        do_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, r, a, v, p);
            if (r) nreq++;
        end
        chk("stall_req_count", nreq, 4);
        chk("stall_ov", v, 1);
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(0, 0, 0, 1, r, a, v, p);
            if (r) begin
                found = 1;
                chk("resume_addr", a, 32'h10);
            end
        end
        chk("resume_found", found, 1);

        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, r, a, v, p);
        chk("pre_redirect_addr", a, 32'h8);
        step(0, 1, 32'h100, 1, r, a, v, p);
        step(0, 0, 0, 1, r, a, v, p);
        chk("redir_req", r, 1);
        chk("redir_addr", a, 32'h100);
        chk("redir_flushed", v, 0);
        step(0, 0, 0, 1, r, a, v, p);
        step(0, 0, 0, 1, r, a, v, p);
        chk("redir_ov", v, 1);
        chk("redir_out_pc", p, 32'h100);

        step(0, 1, 32'h40, 1, r, a, v, p);
        step(0, 1, 32'h80, 1, r, a, v, p);
        first_pc = '0;
        found = 0;
        n40 = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 1, r, a, v, p);
            if (v && !found) begin
                found = 1;
                first_pc = p;
            end
            if (v && p >= 32'h40 && p < 32'h80) n40++;
        end
        chk("b2b_first_pc", first_pc, 32'h80);
        chk("b2b_no_0x40", n40, 0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_issued_dir", perf_issued, 32'(m_issued));
        chk("perf_dropped_dir", perf_dropped, 32'(m_dropped));
`endif

        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, r, a, v, p);
        step(1, 0, 0, 1, r, a, v, p);
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step(0, 0, 0, 1, r, a, v, p);
        chk("rst_idle_req", r, 0);
        step(0, 0, 0, 1, r, a, v, p);
        chk("rst_late_valid", v, 0);
        chk("rst_first_addr", a, 32'h0);

        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom,
                 $urandom_range(0, 2) != 0, r, a, v, p);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_issued", perf_issued, 32'(m_issued));
        chk("perf_dropped", perf_dropped, 32'(m_dropped));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
